match_scoreboard: RTL and testbench
===================================

MATCH_SCOREBOARD -- requirements
Module: match_scoreboard

Interface
REQ-001 The block SHALL have parameter MATCH_ROUNDS, default 7, meaning the best-of-N round count (odd, 1..15).
REQ-002 The block SHALL have parameter LOG_DEPTH, default 4, meaning the number of round-result log entries.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port start  input  1  a request to begin a new match.
REQ-006 The block SHALL have port GAMEOVER  input  1  the round-finished level from the upstream counter.
REQ-007 The block SHALL have port WHO  input  2  the round result from the upstream counter: 10 winner, 01 loser, 00/11 none.
REQ-008 The block SHALL have port clear_out  output  1  a one-cycle clear pulse to the upstream counter.
REQ-009 The block SHALL have port win_rounds  output  4  the number of rounds won by the winner side this match.
REQ-010 The block SHALL have port lose_rounds  output  4  the number of rounds won by the loser side this match.
REQ-011 The block SHALL have port round_cnt  output  4  the number of rounds completed this match, void rounds included.
REQ-012 The block SHALL have port busy  output  1  high while the state is not IDLE or DONE.
REQ-013 The block SHALL have port match_done  output  1  high while in DONE.
REQ-014 The block SHALL have port champion  output  2  the match result: 10 winner, 01 loser, 00 while not DONE.
REQ-015 The block SHALL have port err  output  1  a sticky flag for a void round (WHO 00/11 at a GAMEOVER edge).
REQ-016 The block SHALL have port log_valid  output  1  high when the log holds at least one entry.
REQ-017 The block SHALL have port log_ready  input  1  the consumer pop request.
REQ-018 The block SHALL have port log_data  output  6  the oldest log entry: {round index[3:0], WHO[1:0]}.
REQ-019 The block SHALL have port log_ovf  output  1  a sticky flag for an entry dropped because the log was full.

Function
REQ-020 The FSM SHALL have states IDLE, CLEAR, PLAY, ROUND_END and DONE, and SHALL leave reset in IDLE.
REQ-021 In IDLE or DONE, start=1 SHALL zero win_rounds, lose_rounds, round_cnt, err and champion, then enter CLEAR on the next edge.
REQ-022 start SHALL be ignored in CLEAR, PLAY and ROUND_END.
REQ-023 In CLEAR, clear_out SHALL be 1 for exactly that one cycle, then the FSM SHALL enter PLAY; clear_out SHALL be 0 in every other state.
REQ-024 A registered copy gover_q of GAMEOVER SHALL update every cycle; a round edge is GAMEOVER=1 and gover_q=0, evaluated only in PLAY.
REQ-025 A GAMEOVER level that is still high on entry to PLAY SHALL NOT count as an edge.
REQ-026 On a round edge in PLAY, the block SHALL capture WHO into who_r and SHALL enter ROUND_END on the next cycle.
REQ-027 In ROUND_END, the block SHALL increment round_cnt.
REQ-028 In ROUND_END, who_r=10 SHALL increment win_rounds.
REQ-029 In ROUND_END, who_r=01 SHALL increment lose_rounds.
REQ-030 In ROUND_END, who_r of 00 or 11 SHALL set err and leave both tallies unchanged.
REQ-031 In ROUND_END, the block SHALL push {round_cnt+1, who_r} into the log.
REQ-032 The majority threshold SHALL be MAJ = MATCH_ROUNDS/2+1.
REQ-033 If the post-increment win_rounds or lose_rounds equals MAJ, ROUND_END SHALL go to DONE.
REQ-034 If the post-increment round_cnt equals 15 with neither tally at MAJ, ROUND_END SHALL go to DONE with champion=00.
REQ-035 Otherwise ROUND_END SHALL go to CLEAR.
REQ-036 In DONE, champion SHALL be 10 if win_rounds=MAJ, else 01 if lose_rounds=MAJ, else 00.
REQ-037 All counters SHALL be 4-bit unsigned and SHALL never wrap.
REQ-038 The log SHALL be a LOG_DEPTH-entry FIFO with first-word fall-through; log_data SHALL be valid whenever log_valid=1.
REQ-039 The log SHALL pop when log_valid and log_ready are both 1.
REQ-040 A push when full with no pop in the same cycle SHALL be dropped and SHALL set log_ovf.
REQ-041 A push and a pop in the same cycle SHALL both take effect, including when the log is full; occupancy is then unchanged.
REQ-042 log_ready while empty SHALL have no effect.
REQ-043 The log and log_ovf SHALL persist across matches; start SHALL NOT clear them.

Reset
REQ-044 Asserting rst low SHALL immediately force the state to IDLE and all outputs to 0, empty the log, clear log_ovf and set gover_q=0, whatever the current state.
REQ-045 Normal operation SHALL resume on the first rising clk edge after rst deasserts.

Verification
REQ-046 Bench scenario, full best-of-7 win: start; WHO=10 at 4 GAMEOVER edges -> 4 clear_out pulses (1 initial + 3 inter-round), win_rounds=4, match_done=1, champion=10, round_cnt=4.
REQ-047 Bench scenario, held level: GAMEOVER held high across the CLEAR pulse -> no extra round; round_cnt increments only after GAMEOVER falls and rises again.
REQ-048 Bench scenario, void round: WHO=00 at an edge -> err=1, tallies unchanged, round_cnt+1, log entry {n,00}.
REQ-049 Bench scenario, log full: log_ready=0 for 5 rounds with LOG_DEPTH=4 -> 4 entries held, log_ovf=1; then push and pop in the same cycle -> occupancy stays 4.
REQ-050 Bench scenario, reset mid-operation: rst low in ROUND_END -> IDLE immediately, all outputs 0, log empty; a new start runs a clean match.
REQ-051 Bench scenario, stray start: start pulsed in PLAY -> no effect, tallies preserved.

Source files
------------

// File: rtl/match_scoreboard.sv
// match_scoreboard: best-of-N match tracker driving an upstream round counter, with a round-result log FIFO.
// Ports:
//   clk, rst (async, active low)
//   start                  begin a new match (honoured only in IDLE or DONE)
//   GAMEOVER, WHO          round-finished level and result (10 winner, 01 loser, 00/11 void)
//   clear_out              one-cycle clear pulse to the upstream counter
//   win_rounds, lose_rounds, round_cnt   per-match tallies
//   busy, match_done, champion, err      match status
//   log_valid, log_ready, log_data, log_ovf  first-word fall-through log of {round index, WHO}
module match_scoreboard #(
    parameter int MATCH_ROUNDS = 7,
    parameter int LOG_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       GAMEOVER,
    input  logic [1:0] WHO,
    output logic       clear_out,
    output logic [3:0] win_rounds,
    output logic [3:0] lose_rounds,
    output logic [3:0] round_cnt,
    output logic       busy,
    output logic       match_done,
    output logic [1:0] champion,
    output logic       err,
    output logic       log_valid,
    input  logic       log_ready,
    output logic [5:0] log_data,
    output logic       log_ovf
);
    localparam logic [3:0] MAJ = 4'(MATCH_ROUNDS / 2 + 1);
    localparam int PW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam int CW = $clog2(LOG_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, PLAY, ROUND_END, DONE} state_t;
    state_t state, state_n;

    logic          gover_q;
    logic [1:0]    who_r;
    logic [3:0]    win_n, lose_n, rnd_n;
    logic          round_edge, idle_like, push, pop, full, wr_en;
    logic [5:0]    mem [LOG_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(LOG_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // gover_q runs in every state, so a level still high when PLAY is entered is not an edge
    assign round_edge = (state == PLAY) && GAMEOVER && !gover_q;
    assign idle_like  = (state == IDLE) || (state == DONE);
    assign rnd_n      = (round_cnt == 4'd15) ? round_cnt : round_cnt + 4'd1;
    assign win_n      = win_rounds + 4'(who_r == 2'b10);
    assign lose_n     = lose_rounds + 4'(who_r == 2'b01);

    assign clear_out  = (state == CLEAR);
    assign busy       = !idle_like;
    assign match_done = (state == DONE);
    assign champion   = !match_done ? 2'b00 : (win_rounds == MAJ) ? 2'b10 : (lose_rounds == MAJ) ? 2'b01 : 2'b00;

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: state_n = start ? CLEAR : state;
            CLEAR:      state_n = PLAY;
            PLAY:       state_n = round_edge ? ROUND_END : PLAY;
            ROUND_END:  state_n = (win_n == MAJ || lose_n == MAJ || rnd_n == 4'd15) ? DONE : CLEAR;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            gover_q     <= 1'b0;
            who_r       <= 2'b00;
            win_rounds  <= '0;
            lose_rounds <= '0;
            round_cnt   <= '0;
            err         <= 1'b0;
        end else begin
            state   <= state_n;
            gover_q <= GAMEOVER;
            if (round_edge)
                who_r <= WHO;
            if (idle_like && start) begin
                win_rounds  <= '0;
                lose_rounds <= '0;
                round_cnt   <= '0;
                err         <= 1'b0;
            end else if (state == ROUND_END) begin
                round_cnt   <= rnd_n;
                win_rounds  <= win_n;
                lose_rounds <= lose_n;
                if (who_r[1] == who_r[0])
                    err <= 1'b1;
            end
        end
    end

    // When full, a simultaneous pop frees the slot the write pointer lands on
    assign push      = (state == ROUND_END);
    assign log_valid = (count != '0);
    assign pop       = log_valid && log_ready;
    assign full      = (count == CW'(LOG_DEPTH));
    assign wr_en     = push && (!full || pop);
    assign log_data  = log_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            log_ovf <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= bump(wr_ptr);
            if (pop)
                rd_ptr <= bump(rd_ptr);
            count <= count + CW'(wr_en) - CW'(pop);
            if (push && full && !pop)
                log_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= {rnd_n, who_r};
    end
endmodule

// File: tb/tb_match_scoreboard.sv
// tb_match_scoreboard: directed checks of match_scoreboard with hand-computed expectations.
module tb_match_scoreboard;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       GAMEOVER = 1'b0;
    logic [1:0] WHO = 2'b00;
    logic       log_ready = 1'b0;
    logic       clear_out, busy, match_done, err, log_valid, log_ovf;
    logic [3:0] win_rounds, lose_rounds, round_cnt;
    logic [1:0] champion;
    logic [5:0] log_data;
    int         nchk = 0;
    int         nerr = 0;
    int         clr_cnt = 0;
    int         c0;

    match_scoreboard #(.MATCH_ROUNDS(7), .LOG_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .GAMEOVER(GAMEOVER), .WHO(WHO),
        .clear_out(clear_out), .win_rounds(win_rounds), .lose_rounds(lose_rounds),
        .round_cnt(round_cnt), .busy(busy), .match_done(match_done), .champion(champion),
        .err(err), .log_valid(log_valid), .log_ready(log_ready), .log_data(log_data),
        .log_ovf(log_ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (clear_out) clr_cnt <= clr_cnt + 1;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // leaves the DUT in CLEAR
    task automatic start_match;
        start = 1'b1;
        step;
        start = 1'b0;
    endtask

    // entered in PLAY with GAMEOVER low; leaves the DUT in CLEAR or DONE
    task automatic play_round(input logic [1:0] who, input logic pop);
        GAMEOVER = 1'b1;
        WHO = who;
        step;
        log_ready = pop;
        step;
        log_ready = 1'b0;
        GAMEOVER = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [5:0] exp);
        chk(tag, {2'b00, log_data}, {2'b00, exp});
        log_ready = 1'b1;
        step;
        log_ready = 1'b0;
    endtask

    initial begin
        repeat (3) step;
        chk("rst_busy", busy, 0);
        chk("rst_win", win_rounds, 0);
        chk("rst_rnd", round_cnt, 0);
        chk("rst_clr", clear_out, 0);
        chk("rst_valid", log_valid, 0);
        rst = 1'b1;
        step;
        chk("idle_busy", busy, 0);

        // match 1: four straight wins
        c0 = clr_cnt;
        start_match;
        step;
        for (int i = 0; i < 4; i++) begin
            play_round(2'b10, 1'b0);
            if (i < 3) step;
        end
        chk("m1_win", win_rounds, 4);
        chk("m1_lose", lose_rounds, 0);
        chk("m1_rnd", round_cnt, 4);
        chk("m1_done", match_done, 1);
        chk("m1_champ", champion, 2'b10);
        chk("m1_busy", busy, 0);
        chk("m1_err", err, 0);
        chk("m1_clears", 8'(clr_cnt - c0), 4);
        chk("m1_ovf", log_ovf, 0);
        pop_check("m1_log1", 6'h06);
        pop_check("m1_log2", 6'h0A);
        pop_check("m1_log3", 6'h0E);
        pop_check("m1_log4", 6'h12);
        chk("m1_empty", log_valid, 0);
        log_ready = 1'b1;
        step;
        log_ready = 1'b0;
        chk("empty_pop_valid", log_valid, 0);
        chk("empty_pop_ovf", log_ovf, 0);

        // match 2: held level, stray start, void round, log overflow
        start_match;
        chk("m2_zero_win", win_rounds, 0);
        chk("m2_zero_rnd", round_cnt, 0);
        chk("m2_zero_champ", champion, 0);
        chk("m2_clear", clear_out, 1);
        GAMEOVER = 1'b1;
        WHO = 2'b10;
        repeat (4) step;
        chk("held_rnd", round_cnt, 0);
        chk("held_busy", busy, 1);
        c0 = clr_cnt;
        start = 1'b1;
        step;
        start = 1'b0;
        step;
        chk("stray_rnd", round_cnt, 0);
        chk("stray_clears", 8'(clr_cnt - c0), 0);
        chk("stray_busy", busy, 1);
        GAMEOVER = 1'b0;
        step;
        play_round(2'b10, 1'b0);
        chk("held_after_rnd", round_cnt, 1);
        chk("held_after_win", win_rounds, 1);
        step;
        play_round(2'b01, 1'b0);
        chk("m2_lose1", lose_rounds, 1);
        chk("m2_rnd2", round_cnt, 2);
        step;
        play_round(2'b00, 1'b0);
        chk("void_err", err, 1);
        chk("void_win", win_rounds, 1);
        chk("void_lose", lose_rounds, 1);
        chk("void_rnd", round_cnt, 3);
        pop_check("m2_log1", 6'h06);
        pop_check("m2_log2", 6'h09);
        pop_check("void_log", 6'h0C);
        chk("m2_empty", log_valid, 0);
        play_round(2'b01, 1'b0);
        step;
        play_round(2'b01, 1'b0);
        step;
        play_round(2'b10, 1'b0);
        step;
        play_round(2'b10, 1'b0);
        step;
        play_round(2'b01, 1'b0);
        chk("m2_champ", champion, 2'b01);
        chk("m2_done", match_done, 1);
        chk("m2_rnd", round_cnt, 8);
        chk("m2_win", win_rounds, 3);
        chk("m2_lose", lose_rounds, 4);
        chk("m2_err_sticky", err, 1);
        chk("full_ovf", log_ovf, 1);
        chk("full_head", log_data, 6'h11);

        // match 3: push and pop together while full, then reset in ROUND_END
        start_match;
        chk("m3_ovf_kept", log_ovf, 1);
        chk("m3_log_kept", log_valid, 1);
        chk("m3_err_clr", err, 0);
        step;
        play_round(2'b10, 1'b1);
        chk("m3_ovf", log_ovf, 1);
        pop_check("m3_log1", 6'h15);
        pop_check("m3_log2", 6'h1A);
        pop_check("m3_log3", 6'h1E);
        chk("m3_tail", log_data, 6'h06);
        chk("m3_tail_valid", log_valid, 1);
        GAMEOVER = 1'b1;
        WHO = 2'b01;
        step;
        rst = 1'b0;
        #1;
        chk("mid_rst_win", win_rounds, 0);
        chk("mid_rst_lose", lose_rounds, 0);
        chk("mid_rst_rnd", round_cnt, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", match_done, 0);
        chk("mid_rst_champ", champion, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_clr", clear_out, 0);
        chk("mid_rst_valid", log_valid, 0);
        chk("mid_rst_data", log_data, 0);
        chk("mid_rst_ovf", log_ovf, 0);
        GAMEOVER = 1'b0;
        step;
        rst = 1'b1;
        step;
        chk("post_rst_busy", busy, 0);

        // match 4: clean loser sweep after reset
        start_match;
        step;
        for (int i = 0; i < 4; i++) begin
            play_round(2'b01, 1'b0);
            if (i < 3) step;
        end
        chk("m4_champ", champion, 2'b01);
        chk("m4_lose", lose_rounds, 4);
        chk("m4_win", win_rounds, 0);
        chk("m4_rnd", round_cnt, 4);
        chk("m4_err", err, 0);
        chk("m4_ovf", log_ovf, 0);
        chk("m4_head", log_data, 6'h05);
        chk("m4_done", match_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
